// File: rtl/sub_arb_pkg.sv
// Shared types and constants for the subtractor-sharing arbiter.
// Used by rtl/sub_share_arbiter.sv and its optional SUB_ARB_STATS_EN counters.
package sub_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sub_arb_state_t;

  localparam int SUB_ARB_STAT_W = 16;

  // Saturating increment used by the statistics counters.
  function automatic logic [SUB_ARB_STAT_W-1:0] sat_inc(input logic [SUB_ARB_STAT_W-1:0] v);
    return (v == '1) ? v : v + SUB_ARB_STAT_W'(1);
  endfunction

endpackage

// File: rtl/param_subtractor.sv
// Unsigned wrapping subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
// Purely combinational.
module param_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // The extra top bit of the widened difference is the borrow out.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning from ptr upward,
// wrapping modulo NREQ. Produces a one-hot grant, its index and a found flag.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin sharing of one param_subtractor among NREQ requesters, with a one-entry
// registered result slot. Define SUB_ARB_STATS_EN to add saturating transfer counters.
module sub_share_arbiter
  import sub_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDXW-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_diff,
  output logic                  rsp_borrow
`ifdef SUB_ARB_STATS_EN
  ,
  output logic [SUB_ARB_STAT_W-1:0] stat_ops,
  output logic [SUB_ARB_STAT_W-1:0] stat_borrows
`endif
);

  sub_arb_state_t   state, state_next;
  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  win_idx;
  logic [NREQ-1:0]  win_grant;
  logic             win_found;
  logic             slot_free;
  logic             do_grant;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .found (win_found)
  );

  // rsp_ready feeds req_ready combinationally so a draining slot refills in the same cycle.
  assign slot_free = (state == EMPTY) || rsp_ready;
  assign do_grant  = slot_free && win_found && rst_n;
  assign req_ready = do_grant ? win_grant : '0;
  assign rsp_valid = (state == FULL);

  assign sel_a = req_a[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(win_idx)*WIDTH +: WIDTH];

  param_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a      (sel_a),
    .b      (sel_b),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (win_found) state_next = FULL;
      FULL:    if (rsp_ready && !win_found) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      rsp_id     <= '0;
      rsp_diff   <= '0;
      rsp_borrow <= 1'b0;
    end else if (do_grant) begin
      ptr        <= (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      rsp_id     <= win_idx;
      rsp_diff   <= sub_diff;
      rsp_borrow <= sub_borrow;
    end
  end

`ifdef SUB_ARB_STATS_EN
  logic rsp_xfer;
  assign rsp_xfer = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops     <= '0;
      stat_borrows <= '0;
    end else if (rsp_xfer) begin
      stat_ops <= sat_inc(stat_ops);
      if (rsp_borrow) begin
        stat_borrows <= sat_inc(stat_borrows);
      end
    end
  end
`endif

endmodule
